plc_deserializer: RTL and testbench

Receive-side stage of the PLC link: consumes the one-bit-per-clock serial line driven by the transmit serializer (LSB first) and rebuilds parallel words. Frames are delimited with a start bit and a stop bit. Each completed word is delivered through a single-entry valid/ready output register. Framing faults and output overruns are flagged with one-cycle pulses.

---
 rtl/plc_pkg.sv | 17 +
 rtl/plc_word_buf.sv | 54 +++++
 rtl/plc_deserializer.sv | 77 +++++++
 tb/tb_plc_deserializer.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/plc_pkg.sv
// Shared definitions for the PLC link: receive FSM states, line levels and
// default frame width.
package plc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    STOP = 2'd2
  } plc_rx_state_t;

  localparam logic PLC_IDLE_LEVEL  = 1'b1;
  localparam logic PLC_START_LEVEL = 1'b0;
  localparam logic PLC_STOP_LEVEL  = 1'b1;

  localparam int unsigned PLC_DEFAULT_DATA_BITS = 8;

endpackage : plc_pkg

// File: rtl/plc_word_buf.sv
// Single-entry valid/ready holding register. A load into a full register that
// is not being consumed on the same edge is dropped and flagged as overrun.
module plc_word_buf #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             consume;

  assign consume = valid_q && ready_i;

  // Consume and load on the same edge frees and refills the slot at once.
  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = 1'b0;
    if (load_i && (!valid_q || consume)) begin
      data_d  = data_i;
      valid_d = 1'b1;
    end else if (load_i) begin
      overrun_d = 1'b1;
    end else if (consume) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule : plc_word_buf

// File: rtl/plc_deserializer.sv
// Receive side of the PLC link: start/stop framed, LSB-first serial line in,
// parallel words out through a single-entry valid/ready register.
module plc_deserializer
  import plc_pkg::*;
#(
  parameter int unsigned DATA_BITS = PLC_DEFAULT_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 srl_in,
  output logic [DATA_BITS-1:0] prl_out,
  output logic                 valid_out,
  input  logic                 ready_in,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned           CNT_W    = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(DATA_BITS - 1);

  plc_rx_state_t        state_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 frame_err_q;
  logic                 word_load;

  // A good stop bit hands the word to the output register on that same edge.
  assign word_load = (state_q == STOP) && (srl_in == PLC_STOP_LEVEL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      shreg_q     <= '0;
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (srl_in == PLC_START_LEVEL) begin
            cnt_q   <= '0;
            state_q <= DATA;
          end
        end
        DATA: begin
          shreg_q <= {srl_in, shreg_q[DATA_BITS-1:1]};
          if (cnt_q == CNT_LAST) begin
            state_q <= STOP;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          frame_err_q <= (srl_in != PLC_STOP_LEVEL);
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  plc_word_buf #(
    .WIDTH(DATA_BITS)
  ) u_word_buf (
    .clk      (clk),
    .rst      (rst),
    .load_i   (word_load),
    .data_i   (shreg_q),
    .ready_i  (ready_in),
    .data_o   (prl_out),
    .valid_o  (valid_out),
    .overrun_o(overrun)
  );

  assign frame_err = frame_err_q;

endmodule : plc_deserializer

// File: tb/tb_plc_deserializer.sv
// Directed bench for plc_deserializer with DATA_BITS=8.
module tb_plc_deserializer;

  logic       clk = 1'b0;
  logic       rst;
  logic       srl_in;
  logic [7:0] prl_out;
  logic       valid_out;
  logic       ready_in;
  logic       frame_err;
  logic       overrun;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;
  int unsigned fe_cnt = 0;
  int unsigned ov_cnt = 0;
  bit          rand_ready = 1'b0;
  bit          hold_chk   = 1'b0;

  plc_deserializer #(
    .DATA_BITS(8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .srl_in   (srl_in),
    .prl_out  (prl_out),
    .valid_out(valid_out),
    .ready_in (ready_in),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (overrun)   ov_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one line bit, clock it, and sample #1 after the edge.
  task automatic send_bit(input logic b);
    logic       pv, pr;
    logic [7:0] pd;
    srl_in = b;
    if (rand_ready) ready_in = 1'($urandom_range(0, 1));
    pv = valid_out;
    pr = ready_in;
    pd = prl_out;
    @(posedge clk);
    #1;
    if (hold_chk && pv && !pr) chk("hold", {24'h0, prl_out}, {24'h0, pd});
  endtask

  task automatic send_frame(input logic [7:0] w);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(w[i]);
    send_bit(1'b1);
  endtask

  task automatic consume();
    ready_in = 1'b1;
    send_bit(1'b1);
    ready_in = 1'b0;
    chk("consume_valid", {31'h0, valid_out}, 32'h0);
  endtask

  initial begin
    logic [11:0] vec;
    int unsigned fe0, ov0;

    rst = 1'b1; srl_in = 1'b1; ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rst_prl",   {24'h0, prl_out}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_fe",    {31'h0, frame_err}, 32'h0);
    chk("rst_ov",    {31'h0, overrun}, 32'h0);

    // Good frame: idle,idle,start,1,0,1,0,0,1,0,1,stop -> 0xA5
    vec = 12'b1101_0100_1011;
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 11; i >= 0; i--) begin
      send_bit(vec[i]);
      if (i == 1) chk("a5_early_valid", {31'h0, valid_out}, 32'h0);
    end
    chk("a5_prl",   {24'h0, prl_out}, 32'hA5);
    chk("a5_valid", {31'h0, valid_out}, 32'h1);
    chk("a5_pulses", fe_cnt - fe0 + ov_cnt - ov0, 32'h0);
    consume();

    // Bad stop bit, then an immediate good frame
    fe0 = fe_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(1'b1);
    send_bit(1'b0);
    chk("bad_fe",    {31'h0, frame_err}, 32'h1);
    chk("bad_valid", {31'h0, valid_out}, 32'h0);
    send_frame(8'h3C);
    chk("bad_fe_count", fe_cnt - fe0, 32'h1);
    chk("3c_prl",   {24'h0, prl_out}, 32'h3C);
    chk("3c_valid", {31'h0, valid_out}, 32'h1);
    consume();

    // Overrun with ready held low
    ov0 = ov_cnt; fe0 = fe_cnt;
    send_frame(8'h11);
    chk("ov_first_prl", {24'h0, prl_out}, 32'h11);
    send_frame(8'h22);
    chk("ov_pulse", {31'h0, overrun}, 32'h1);
    chk("ov_prl",   {24'h0, prl_out}, 32'h11);
    chk("ov_valid", {31'h0, valid_out}, 32'h1);
    chk("ov_fe",    {31'h0, frame_err}, 32'h0);
    send_bit(1'b1);
    chk("ov_pulse_end", {31'h0, overrun}, 32'h0);
    chk("ov_count", ov_cnt - ov0, 32'h1);
    consume();

    // Consume and load on the same edge
    ov0 = ov_cnt;
    send_frame(8'h11);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(vec[0] ^ vec[0] ^ ((8'h22 >> i) & 1'b1));
    ready_in = 1'b1;
    send_bit(1'b1);
    ready_in = 1'b0;
    chk("sim_ov",    {31'h0, overrun}, 32'h0);
    chk("sim_prl",   {24'h0, prl_out}, 32'h22);
    chk("sim_valid", {31'h0, valid_out}, 32'h1);
    chk("sim_ov_count", ov_cnt - ov0, 32'h0);
    consume();

    // Reset after 4 payload bits
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0);
    rst = 1'b1;
    send_bit(1'b1);
    rst = 1'b0;
    chk("mr_prl",   {24'h0, prl_out}, 32'h0);
    chk("mr_valid", {31'h0, valid_out}, 32'h0);
    for (int i = 0; i < 5; i++) send_bit(1'b1);
    chk("mr_stale_valid", {31'h0, valid_out}, 32'h0);
    chk("mr_pulses", fe_cnt - fe0 + ov_cnt - ov0, 32'h0);
    send_frame(8'h5A);
    chk("5a_prl",   {24'h0, prl_out}, 32'h5A);
    chk("5a_valid", {31'h0, valid_out}, 32'h1);
    consume();

    // Long idle, then frames with a randomly toggling consumer
    fe0 = fe_cnt; ov0 = ov_cnt;
    for (int i = 0; i < 100; i++) send_bit(1'b1);
    chk("idle_valid",  {31'h0, valid_out}, 32'h0);
    chk("idle_prl",    {24'h0, prl_out}, 32'h5A);
    chk("idle_pulses", fe_cnt - fe0 + ov_cnt - ov0, 32'h0);
    rand_ready = 1'b1;
    hold_chk   = 1'b1;
    for (int f = 0; f < 12; f++) begin
      send_frame(8'(f * 37 + 5));
      send_bit(1'b1);
    end
    rand_ready = 1'b0;
    hold_chk   = 1'b0;
    ready_in   = 1'b0;
    chk("rand_fe", fe_cnt - fe0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_plc_deserializer
